// File: rtl/instruction_fetch_mem.sv
// Clocked instruction memory: valid/ready fetch port, 1-cycle registered read, run-time load port.
// Optional build macro IMEM_PARITY_EN adds a per-word even-parity bit checked on fetch.
module instruction_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 128,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_nxt;

    // Power-up content is all zeros; reset deliberately leaves it alone.
    logic [MEM_W-1:0] mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             rd_in_range, wr_in_range;
    logic             accept;
    logic [MEM_W-1:0] rd_word;
    logic [MEM_W-1:0] wr_word;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;

    assign rd_idx      = req_addr[IDX_W+1:2];
    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign rd_in_range = (req_addr >> (IDX_W + 2)) == '0;
    assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;

    assign rsp_valid = (state == FULL);
    assign req_ready = ~rsp_valid | rsp_ready;
    assign accept    = req_valid & req_ready;

    assign rd_word = mem[rd_idx];

`ifdef IMEM_PARITY_EN
    // Even parity: the stored bit makes the XOR of the whole stored word zero.
    assign wr_word = {^wr_data, wr_data};

    always_comb begin
        fetch_instr = rd_word[DATA_W-1:0];
        fetch_err   = 1'b0;
        if (!rd_in_range || (^rd_word)) begin
            fetch_instr = NOP_WORD;
            fetch_err   = 1'b1;
        end
    end
`else
    assign wr_word = wr_data;

    always_comb begin
        fetch_instr = rd_word;
        fetch_err   = 1'b0;
        if (!rd_in_range) begin
            fetch_instr = NOP_WORD;
            fetch_err   = 1'b1;
        end
    end
`endif

    // Load port; the fetch register samples the old word on a same-index collision.
    always_ff @(posedge Clk) begin
        if (wr_en && wr_in_range)
            mem[wr_idx] <= wr_word;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output stage only loads on an accepted request, so it holds while stalled.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rsp_instr <= NOP_WORD;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_instr <= fetch_instr;
            rsp_err   <= fetch_err;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Directed + random bench for instruction_fetch_mem against a word-array reference model.
module tb_instruction_fetch_mem;

    localparam int DEPTH = 128;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    instruction_fetch_mem dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain word array plus a one-entry response slot.
    logic [31:0] ref_mem [DEPTH];
    bit          corrupt [DEPTH];
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_err;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a / 4) % DEPTH;
    endfunction

    // Inputs are applied just after an edge; check ready, advance the model, cross one edge, check outputs.
    task automatic cyc();
        bit acc;
        #2;
        chk("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
        acc = req_valid && (!m_valid || rsp_ready);
        if (acc) begin
            if (!in_range(req_addr) || corrupt[word_of(req_addr)]) begin
                m_instr = 32'h0;
                m_err   = 1'b1;
            end else begin
                m_instr = ref_mem[word_of(req_addr)];
                m_err   = 1'b0;
            end
            m_valid = 1'b1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        if (wr_en && in_range(wr_addr)) begin
            ref_mem[word_of(wr_addr)] = wr_data;
            corrupt[word_of(wr_addr)] = 1'b0;
        end
        @(posedge Clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_instr", rsp_instr, m_instr);
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b0; rsp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        req_valid = 1'b1; req_addr = a; rsp_ready = rr;
        cyc();
    endtask

    task automatic idle();
        req_valid = 1'b0; rsp_ready = 1'b1; wr_en = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            corrupt[i] = 1'b0;
        end
        m_valid = 1'b0; m_instr = '0; m_err = 1'b0;

        // Reset state
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_instr", rsp_instr, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Program load, then back-to-back fetches at full throughput
        write_word(32'h00, 32'h20090006);
        write_word(32'h18, 32'h200a0008);
        fetch(32'h00, 1'b1);
        chk("b2b_first", rsp_instr, 32'h20090006);
        fetch(32'h18, 1'b1);
        chk("b2b_second", rsp_instr, 32'h200a0008);
        chk("b2b_ready", 32'(req_ready), 32'h1);

        // Stall: response holds and the pending request at 0x00 waits
        fetch(32'h18, 1'b1);
        for (int k = 0; k < 3; k++) begin
            fetch(32'h00, 1'b0);
            chk("stall_hold", rsp_instr, 32'h200a0008);
            chk("stall_ready", 32'(req_ready), 32'h0);
        end
        fetch(32'h00, 1'b1);
        chk("stall_release", rsp_instr, 32'h20090006);
        idle();

        // Out-of-range fetch and write
        fetch(32'h200, 1'b1);
        chk("oor_instr", rsp_instr, 32'h0);
        chk("oor_err", 32'(rsp_err), 32'h1);
        write_word(32'h200, 32'hdeadbeef);
        for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), 1'b1);
        idle();

        // Same-edge write and fetch of one index returns the old word
        wr_en = 1'b1; wr_addr = 32'h48; wr_data = 32'h000b60c0;
        fetch(32'h48, 1'b1);
        chk("read_first", rsp_instr, 32'h0);
        wr_en = 1'b0;
        fetch(32'h48, 1'b1);
        chk("write_visible", rsp_instr, 32'h000b60c0);
        idle();

        // Asynchronous reset while stalled with a valid response
        fetch(32'h18, 1'b1);
        req_valid = 1'b0; rsp_ready = 1'b0;
        cyc();
        Reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_instr", rsp_instr, 32'h0);
        chk("async_rst_err", 32'(rsp_err), 32'h0);
        m_valid = 1'b0; m_instr = '0; m_err = 1'b0;
        #3;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        fetch(32'h00, 1'b1);
        chk("mem_survives_reset", rsp_instr, 32'h20090006);
        idle();

`ifdef IMEM_PARITY_EN
        dut.mem[24] = dut.mem[24] ^ 33'h1;
        corrupt[24] = 1'b1;
        fetch(32'h60, 1'b1);
        chk("parity_err", 32'(rsp_err), 32'h1);
        chk("parity_instr", rsp_instr, 32'h0);
        idle();
`endif

        // Random traffic with backpressure, collisions and out-of-range addresses
        for (int n = 0; n < 600; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                req_addr = $urandom | 32'h200;
            else
                req_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)
                wr_addr = $urandom | 32'h200;
            else if ($urandom_range(0, 1) == 0)
                wr_addr = req_addr;
            else
                wr_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
            wr_data = $urandom;
            cyc();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
